// File: rtl/stage_3.sv
// stage_3: third butterfly stage of an 8-point forward DCT on IEEE-754
// single-precision words. One combinational add/sub per butterfly leg,
// results registered with a one-clock latency and a matching valid flag.
module stage_3 (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [31:0] N0,
  input  logic [31:0] N1,
  input  logic [31:0] N2,
  input  logic [31:0] N3,
  input  logic [31:0] N4,
  input  logic [31:0] N5,
  input  logic [31:0] N6,
  input  logic [31:0] N7,
  output logic [31:0] O0,
  output logic [31:0] O1,
  output logic [31:0] O2,
  output logic [31:0] O3,
  output logic [31:0] O4,
  output logic [31:0] O5,
  output logic [31:0] O6,
  output logic [31:0] O7,
  output logic        valid
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned EXT_W  = 27;  // hidden bit + 23 fraction + guard/round/sticky

  localparam logic [WORD_W-1:0] QNAN = 32'h7FC0_0000;

  // Truncating single-precision adder; denormal inputs read as zero, denormal
  // or exactly-zero results come out as +0.
  function automatic logic [WORD_W-1:0] fp_add(input logic [WORD_W-1:0] a,
                                               input logic [WORD_W-1:0] b);
    logic             sa, sb, sl, ss;
    logic [7:0]       ea, eb, el, es, diff;
    logic [22:0]      fa, fb, fl, fs;
    logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [EXT_W-1:0] xl, xs, xs_sh, norm;
    logic             sticky;
    logic [EXT_W:0]   sum;
    int               p;
    int               e;
    logic [WORD_W-1:0] r;

    sa = a[31]; ea = a[30:23]; fa = a[22:0];
    sb = b[31]; eb = b[30:23]; fb = b[22:0];
    a_nan  = (ea == 8'hFF) && (fa != 23'd0);
    b_nan  = (eb == 8'hFF) && (fb != 23'd0);
    a_inf  = (ea == 8'hFF) && (fa == 23'd0);
    b_inf  = (eb == 8'hFF) && (fb == 23'd0);
    a_zero = (ea == 8'h00);
    b_zero = (eb == 8'h00);

    r      = 32'h0;
    sl     = 1'b0; ss = 1'b0;
    el     = 8'h0; es = 8'h0;
    fl     = 23'h0; fs = 23'h0;
    diff   = 8'h0;
    xl     = '0; xs = '0; xs_sh = '0; norm = '0;
    sticky = 1'b0;
    sum    = '0;
    p      = 0;
    e      = 0;

    if (a_nan || b_nan) begin
      r = QNAN;
    end else if (a_inf && b_inf) begin
      r = (sa == sb) ? a : QNAN;
    end else if (a_inf) begin
      r = a;
    end else if (b_inf) begin
      r = b;
    end else if (a_zero && b_zero) begin
      r = 32'h0;
    end else if (a_zero) begin
      r = b;
    end else if (b_zero) begin
      r = a;
    end else begin
      // Larger magnitude first so the mantissa difference never goes negative
      if ({ea, fa} >= {eb, fb}) begin
        sl = sa; el = ea; fl = fa;
        ss = sb; es = eb; fs = fb;
      end else begin
        sl = sb; el = eb; fl = fb;
        ss = sa; es = ea; fs = fa;
      end
      diff = el - es;
      xl   = {1'b1, fl, 3'b000};
      xs   = {1'b1, fs, 3'b000};

      // Align the smaller operand; anything shifted out folds into the sticky bit
      if (diff >= 8'd27) begin
        xs_sh = 27'd1;
      end else begin
        xs_sh  = xs >> diff;
        sticky = ((xs_sh << diff) != xs);
        xs_sh[0] = xs_sh[0] | sticky;
      end

      if (sl == ss) sum = {1'b0, xl} + {1'b0, xs_sh};
      else          sum = {1'b0, xl} - {1'b0, xs_sh};

      if (sum == '0) begin
        r = 32'h0;
      end else begin
        if (sum[EXT_W]) begin
          norm = sum[EXT_W:1];
          e    = int'(el) + 1;
        end else begin
          for (int i = 0; i < EXT_W; i++) begin
            if (sum[i]) p = i;
          end
          norm = sum[EXT_W-1:0] << (26 - p);
          e    = int'(el) - (26 - p);
        end

        if (e >= 255)    r = {sl, 8'hFF, 23'h0};
        else if (e <= 0) r = 32'h0;
        else             r = {sl, 8'(e), 23'(norm >> 3)};
      end
    end
    return r;
  endfunction

  logic [WORD_W-1:0] res_c [8];

  // Butterfly legs; subtraction flips the sign of the second operand
  always_comb begin
    res_c[0] = fp_add(N0, N1);
    res_c[1] = fp_add(N0, {~N1[31], N1[30:0]});
    res_c[2] = N2;
    res_c[3] = N3;
    res_c[4] = fp_add(N4, N6);
    res_c[5] = fp_add(N7, {~N5[31], N5[30:0]});
    res_c[6] = fp_add(N4, {~N6[31], N6[30:0]});
    res_c[7] = fp_add(N7, N5);
  end

  // Output registers: reset clears, en loads, otherwise hold with valid low
  always_ff @(posedge clk) begin
    if (!reset) begin
      O0    <= 32'h0;
      O1    <= 32'h0;
      O2    <= 32'h0;
      O3    <= 32'h0;
      O4    <= 32'h0;
      O5    <= 32'h0;
      O6    <= 32'h0;
      O7    <= 32'h0;
      valid <= 1'b0;
    end else if (en) begin
      O0    <= res_c[0];
      O1    <= res_c[1];
      O2    <= res_c[2];
      O3    <= res_c[3];
      O4    <= res_c[4];
      O5    <= res_c[5];
      O6    <= res_c[6];
      O7    <= res_c[7];
      valid <= 1'b1;
    end else begin
      valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stage_3.sv
// Directed bench for stage_3 with hand-computed expected words.
module tb_stage_3;

  logic        clk;
  logic        reset;
  logic        en;
  logic [31:0] n [8];
  logic [31:0] o [8];
  logic        valid;

  int n_checks;
  int n_fail;

  stage_3 dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .N0 (n[0]), .N1 (n[1]), .N2 (n[2]), .N3 (n[3]),
    .N4 (n[4]), .N5 (n[5]), .N6 (n[6]), .N7 (n[7]),
    .O0 (o[0]), .O1 (o[1]), .O2 (o[2]), .O3 (o[3]),
    .O4 (o[4]), .O5 (o[5]), .O6 (o[6]), .O7 (o[7]),
    .valid (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for every check in the bench
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] exp [8]);
    for (int i = 0; i < 8; i++) check($sformatf("%s.O%0d", tag, i), o[i], exp[i]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] zero8  [8];
  logic [31:0] basic  [8];
  logic [31:0] exp_v  [8];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    zero8 = '{8{32'h0}};
    basic = '{32'h40400000, 32'hBF800000, 32'h40400000, 32'h40800000,
              32'h41400000, 32'h40000000, 32'hC0000000, 32'h41600000};

    // Reset held with en=1 and live operands
    reset = 1'b0;
    en    = 1'b1;
    n = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
          32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
    tick();
    check_all("rst", zero8);
    check("rst.valid", {31'h0, valid}, 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("rst_hold%0d.O0", k), o[0], 32'h0);
      check($sformatf("rst_hold%0d.O7", k), o[7], 32'h0);
      check($sformatf("rst_hold%0d.valid", k), {31'h0, valid}, 32'h0);
    end

    // Basic vector 1.0..8.0 after release
    reset = 1'b1;
    tick();
    check_all("basic", basic);
    check("basic.valid", {31'h0, valid}, 32'h1);

    // Enable low: outputs hold, valid drops
    en = 1'b0;
    n = '{32'h12345678, 32'h9ABCDEF0, 32'h11111111, 32'h22222222,
          32'h33333333, 32'h44444444, 32'h55555555, 32'h66666666};
    tick();
    check_all("hold", basic);
    check("hold.valid", {31'h0, valid}, 32'h0);

    // Cancellation to +0, sign, pass-through of NaN payload and denormal
    en = 1'b1;
    n = '{32'h40A00000, 32'h40A00000, 32'h7FC12345, 32'h00000001,
          32'hC0000000, 32'h3F800000, 32'hC0000000, 32'h3F800000};
    tick();
    exp_v = '{32'h41200000, 32'h00000000, 32'h7FC12345, 32'h00000001,
              32'hC0800000, 32'h00000000, 32'h00000000, 32'h40000000};
    check_all("cancel", exp_v);
    check("cancel.valid", {31'h0, valid}, 32'h1);

    // Alignment with truncation, and infinities
    n = '{32'h4B800000, 32'h3F800000, 32'h00000000, 32'h80000000,
          32'h7F800000, 32'h40000000, 32'h7F800000, 32'hFF800000};
    tick();
    exp_v = '{32'h4B800000, 32'h4B7FFFFF, 32'h00000000, 32'h80000000,
              32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'hFF800000};
    check_all("align_inf", exp_v);

    // Overflow, denormal operand treated as zero, small exponent differences
    n = '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h3F800000, 32'h3F800000,
          32'h00000005, 32'h3F800000, 32'h3F800000, 32'h3FC00000};
    tick();
    exp_v = '{32'h7F800000, 32'h00000000, 32'h3F800000, 32'h3F800000,
              32'h3F800000, 32'h3F000000, 32'hBF800000, 32'h40200000};
    check_all("ovf", exp_v);

    // Denormal result flushed to +0; carry out at the bottom of the range; NaN operand
    n = '{32'h00800001, 32'h00800000, 32'h00000000, 32'h00000000,
          32'h7FC00001, 32'h3F800000, 32'h3F800000, 32'h3F800000};
    tick();
    check("flush.O0", o[0], 32'h01000000);
    check("flush.O1", o[1], 32'h00000000);
    check("nan.O4", o[4], 32'h7FC00000);
    check("nan.O6", o[6], 32'h7FC00000);

    // Reset mid-stream discards the in-flight result
    reset = 1'b0;
    tick();
    check_all("mid_rst", zero8);
    check("mid_rst.valid", {31'h0, valid}, 32'h0);
    reset = 1'b1;
    en    = 1'b0;
    n = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
          32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
    tick();
    check("post_rst_idle.valid", {31'h0, valid}, 32'h0);
    check("post_rst_idle.O0", o[0], 32'h0);
    en = 1'b1;
    tick();
    check_all("post_rst", basic);
    check("post_rst.valid", {31'h0, valid}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stage_3.md
STAGE_3 -- requirements
Module: stage_3

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset (0 = reset), sampled on rising clk.
REQ-004 en  input  1  enable; when 1, the block samples its inputs on the rising clk edge.
REQ-005 N0..N7  input  32 each  operands, IEEE-754 single-precision floats.
REQ-006 O0..O7  output  32 each  registered results, IEEE-754 single-precision floats.
REQ-007 valid  output  1  registered; 1 while O0..O7 hold results of an enabled sample.

Function
REQ-008 The block SHALL compute one third-stage butterfly of an 8-point forward DCT:
- O0=N0+N1
- O1=N0-N1
- O2=N2
- O3=N3
- O4=N4+N6
- O5=N7-N5
- O6=N4-N6
- O7=N7+N5
REQ-009 The block SHALL implement a combinational single-precision adder/subtractor; subtraction SHALL be performed by inverting the sign of the second operand.
- Operand alignment: by exponent difference.
- Mantissa: add or subtract, then normalize.
- Rounding: round toward zero (truncation).
REQ-010 Special operands:
- Denormal inputs SHALL be treated as zero.
- Denormal results SHALL be flushed to +0.
- An exact zero result SHALL be encoded as +0 (0x00000000).
REQ-011 Overflow and non-finite values:
- Exponent overflow SHALL produce a correctly signed infinity.
- Any NaN input, or inf-inf of opposite effective sign, SHALL produce 0x7FC00000.
- Inf plus a finite value SHALL give that inf.
REQ-012 Latency SHALL be one clock: results of inputs sampled at edge k appear on O0..O7 after edge k.
REQ-013 On a rising edge with reset=1 and en=1: O0..O7 SHALL load the REQ-008 results and valid SHALL become 1.
REQ-014 On a rising edge with reset=1 and en=0: O0..O7 SHALL hold their previous values and valid SHALL become 0.
REQ-015 Pass-through outputs O2/O3 SHALL be bit-exact copies of N2/N3, including NaN payloads and denormals.
REQ-016 Inputs changing while en=1 SHALL be accepted every cycle with no backpressure; throughput is one 8-word vector per clock.

Reset
REQ-017 On a rising edge with reset=0: O0..O7 SHALL become 0x00000000 and valid SHALL become 0, regardless of en.
REQ-018 Reset SHALL take priority over en.
REQ-019 Reset asserted mid-stream SHALL discard the in-flight result; the first valid after release SHALL appear one edge after the first enabled sampling edge with reset=1.
REQ-020 There SHALL be no asynchronous behaviour; outputs SHALL change only on rising clk edges.

Verification
REQ-021 Basic vector:
- Stimulus: N0..N7 = 1.0..8.0 (0x3F800000, 0x40000000, 0x40400000, 0x40800000, 0x40A00000, 0x40C00000, 0x40E00000, 0x41000000), en=1, reset held 0 for one edge then released.
- Required: O0..O7 = 0x40400000, 0xBF800000, 0x40400000, 0x40800000, 0x41400000, 0x40000000, 0xC0000000, 0x41600000; valid=1 one edge after release.
REQ-022 Reset hold:
- Stimulus: reset=0 for several edges with en=1 and arbitrary N.
- Required: all O = 0x00000000 and valid=0 throughout.
REQ-023 Enable hold:
- Stimulus: after REQ-021, drop en to 0 and change N0..N7.
- Required: O0..O7 unchanged; valid=0 after the next edge.
REQ-024 Cancellation and sign:
- Stimulus: N0=N1=0x40A00000, N4=N6=0xC0000000.
- Required: O1=0x00000000 and O6=0x00000000 (+0); O0=0x41200000; O4=0xC0800000.
REQ-025 Alignment and truncation:
- Stimulus: N0=0x4B800000 (2^24), N1=0x3F800000 (1.0).
- Required: O0=0x4B800000 (truncated); O1=0x4B7FFFFF.
REQ-026 Specials:
- Stimulus: N4=0x7F800000 (+inf), N6=0x7F800000.
- Required: O4=0x7F800000 and O6=0x7FC00000.
- Stimulus: N0=N1=0x7F7FFFFF (max finite).
- Required: O0=0x7F800000.
